// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state encodings for the memory arbiter
package mem_arbiter_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;
  localparam logic [1:0] S_TURN = 2'd3;
endpackage

// File: rtl/mem_arbiter_bus_mux.sv
// mem_arbiter_bus_mux: steers the owning master onto the slave port and gates ready back
module mem_arbiter_bus_mux #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  own_valid_i,
  input  logic                  own_id_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  input  logic                  m0_re_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  input  logic                  m1_re_i,
  input  logic                  m1_we_i,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic                  m0_ready_o,
  output logic                  m1_ready_o
);
  assign mem_addr_o = !own_valid_i ? '0 : own_id_i ? m1_addr_i : m0_addr_i;
  assign mem_data_o = !own_valid_i ? '0 : own_id_i ? m1_data_i : m0_data_i;
  assign mem_re_o   = own_valid_i & (own_id_i ? m1_re_i : m0_re_i);
  assign mem_we_o   = own_valid_i & (own_id_i ? m1_we_i : m0_we_i);
  assign m0_ready_o = own_valid_i & !own_id_i & mem_ready_i;
  assign m1_ready_o = own_valid_i & own_id_i & mem_ready_i;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin bus arbiter with burst hold, bounded preemption and turnaround
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_dataOut,
  input  logic                  m0_re,
  input  logic                  m0_we,
  output logic [DATA_WIDTH-1:0] m0_dataIn,
  output logic                  m0_ready,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_dataOut,
  input  logic                  m1_re,
  input  logic                  m1_we,
  output logic [DATA_WIDTH-1:0] m1_dataIn,
  output logic                  m1_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dataOut,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dataIn,
  input  logic                  mem_ready,
  output logic                  gnt_valid,
  output logic                  gnt_id
);
  localparam logic [CNT_WIDTH:0] MAXB = (CNT_WIDTH+1)'(MAX_BURST);
  localparam logic [CNT_WIDTH:0] ONE  = (CNT_WIDTH+1)'(1);
  logic [1:0] state_q, state_d;
  logic last_owner_q, last_owner_d, next_owner_q, next_owner_d;
  logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_WIDTH:0] cnt_inc;
  logic req0, req1, own_valid, own_id, req_own, req_oth, preempt, idle_pick, turn_pick;
  assign req0      = m0_re | m0_we;
  assign req1      = m1_re | m1_we;
  assign own_valid = (state_q == S_OWN0) | (state_q == S_OWN1);
  assign own_id    = state_q == S_OWN1;
  assign req_own   = own_id ? req1 : req0;
  assign req_oth   = own_id ? req0 : req1;
  assign cnt_inc   = {1'b0, burst_cnt_q} + ONE;
  assign preempt   = (MAX_BURST != 0) & mem_ready & (cnt_inc >= MAXB) & req_oth;
  assign idle_pick = (req0 & req1) ? ~last_owner_q : req1;
  assign turn_pick = (next_owner_q ? req1 : req0) ? next_owner_q : ~next_owner_q;
  assign gnt_valid = own_valid;
  assign gnt_id    = own_id;
  assign m0_dataIn = mem_dataIn;
  assign m1_dataIn = mem_dataIn;
  mem_arbiter_bus_mux #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_mux (
    .own_valid_i(own_valid), .own_id_i(own_id),
    .m0_addr_i(m0_addr), .m0_data_i(m0_dataOut), .m0_re_i(m0_re), .m0_we_i(m0_we),
    .m1_addr_i(m1_addr), .m1_data_i(m1_dataOut), .m1_re_i(m1_re), .m1_we_i(m1_we),
    .mem_ready_i(mem_ready),
    .mem_addr_o(mem_addr), .mem_data_o(mem_dataOut), .mem_re_o(mem_re), .mem_we_o(mem_we),
    .m0_ready_o(m0_ready), .m1_ready_o(m1_ready)
  );
  // Next-state: grant selection, owner release/preemption and burst counting
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    next_owner_d = next_owner_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      S_IDLE: if (req0 | req1) begin
        state_d      = idle_pick ? S_OWN1 : S_OWN0;
        last_owner_d = idle_pick;
        burst_cnt_d  = '0;
      end
      S_TURN: begin
        state_d = !(req0 | req1) ? S_IDLE : turn_pick ? S_OWN1 : S_OWN0;
        if (req0 | req1) begin
          last_owner_d = turn_pick;
          burst_cnt_d  = '0;
        end
      end
      default: begin
        if (mem_ready && cnt_inc <= MAXB) burst_cnt_d = cnt_inc[CNT_WIDTH-1:0];
        if (!req_own) state_d = req_oth ? S_TURN : S_IDLE;
        else if (preempt) state_d = S_TURN;
        if (!req_own || preempt) next_owner_d = ~own_id;
      end
    endcase
  end
  // State registers with synchronous reset; master 0 wins the first tie
  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= S_IDLE;
      last_owner_q <= 1'b1;
      next_owner_q <= 1'b0;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      next_owner_q <= next_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter on the word-level memory bus (addr / dataOut / re / we / dataIn / ready).
- Sits directly downstream of the instruction cache and the data cache, on their outward memory ports, and drives the single main-memory/bus port.
- Holds grant across cache block fills and write-backs, with round-robin tie-break and bounded-burst preemption at word boundaries.
- Inserts one turnaround cycle on every owner change.

Parameters:
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width on all ports
- MAX_BURST, 16, completed words before the owner can be preempted when the other master waits; 0 disables preemption
- CNT_WIDTH, 8, burst counter width; must satisfy MAX_BURST < 2^CNT_WIDTH

Ports:
- clk  in  1  clock
- res  in  1  reset: synchronous, active-high
- m0_addr  in  ADDR_WIDTH  master 0 (I-cache) word address
- m0_dataOut  in  DATA_WIDTH  master 0 write data
- m0_re  in  1  master 0 read request
- m0_we  in  1  master 0 write request
- m0_dataIn  out  DATA_WIDTH  read data to master 0
- m0_ready  out  1  master 0 word-complete strobe
- m1_addr, m1_dataOut, m1_re, m1_we, m1_dataIn, m1_ready: same as m0, for master 1 (D-cache)
- mem_addr  out  ADDR_WIDTH  slave address
- mem_dataOut  out  DATA_WIDTH  slave write data
- mem_re  out  1  slave read request
- mem_we  out  1  slave write request
- mem_dataIn  in  DATA_WIDTH  slave read data
- mem_ready  in  1  slave word-complete strobe
- gnt_valid  out  1  a master currently owns the slave
- gnt_id  out  1  owning master index (valid only when gnt_valid=1)

Behaviour:
- Bus protocol (masters and slave):
  - A request is re or we high.
  - Addr, data and re/we are held stable until the ready strobe.
  - One word completes per ready-high cycle.
  - A master may change addr in the cycle after ready and keep the request high to continue a burst.
  - re and we together is illegal.
- req_k = mk_re | mk_we.
- States: S_IDLE, S_OWN0, S_OWN1, S_TURN. Registers: state, last_owner, burst_cnt, next_owner.
- Reset (res high at a clock edge):
  - state=S_IDLE, last_owner=1 (master 0 wins the first tie), burst_cnt=0.
  - Next cycle: mem_re=mem_we=0, mem_addr=0, mem_dataOut=0, m0_ready=m1_ready=0, gnt_valid=0, gnt_id=0.
  - Reset mid-burst abandons any in-flight access; the slave sees the request drop in the cycle after reset is sampled.
- S_IDLE:
  - Slave outputs zero.
  - Only req_0 → S_OWN0. Only req_1 → S_OWN1.
  - Both → S_OWN of the master that is not last_owner.
  - None → stay.
  - Arbitration latency is one cycle from request to the forwarded mem request.
- S_OWNk:
  - mem_* = mk_* combinationally. mk_ready = mem_ready. Other master's ready = 0.
  - mem_dataIn is fanned out to both mk_dataIn.
  - gnt_valid=1, gnt_id=k.
  - On entry: last_owner←k, burst_cnt←0.
  - Each mem_ready: burst_cnt increments, saturating at MAX_BURST.
- Transitions out of S_OWNk (evaluated every cycle; priority order):
  1. req_k=0 and other requesting → S_TURN, next_owner=other.
  2. req_k=0 and no other request → S_IDLE.
  3. Preemption: MAX_BURST≠0, mem_ready=1, burst_cnt+1 ≥ MAX_BURST, other requesting → S_TURN, next_owner=other.
     - Preemption happens only on a ready cycle, so no access is cut mid-word.
     - The preempted master keeps its request high and simply sees ready=0 until regranted.
  4. Otherwise stay.
- S_TURN:
  - Exactly one cycle. mem_re=mem_we=0, all ready=0, gnt_valid=0.
  - If next_owner is still requesting → S_OWN of next_owner.
  - Else if the other master is requesting → S_OWN of that master.
  - Else → S_IDLE.
- mem_ready outside S_OWNk is ignored (no ready forwarded, no counting).
- Simultaneous new requests in the same cycle as owner release are resolved via S_TURN; there is no direct S_OWN0↔S_OWN1 edge.
- Illegal re&we from the owner is forwarded unchanged; the bench flags it.

Decomposition:
- State encodings (2-bit) and bus-protocol macros go in a shared include alongside DataBus.vh, e.g. arbiter.vh: `ARB_S_IDLE, `ARB_S_OWN0, `ARB_S_OWN1, `ARB_S_TURN.
- One natural sub-module: bus_mux (combinational select of master signals onto the slave port, plus ready gating, by owner/valid).
- The FSM and counter stay in mem_arbiter.

Test Plan:
- Reset then idle: res=1 for 2 cycles → all outputs 0, gnt_valid=0; m0_re=1 with addr 0x100 → mem_re=1, mem_addr=0x100 one cycle later.
- Tie after reset: m0_re and m1_we raised the same cycle → master 0 granted first; after m0 drops, one S_TURN cycle with mem_re=mem_we=0, then m1 owns with mem_we=1.
- Full I-cache fill: m0 bursts 16 words at 0x200..0x23C, mem_ready every 2nd cycle, m1 idle → 16 m0_ready strobes, no turnaround, addresses forwarded in order.
- Preemption: MAX_BURST=4, m0 bursting, m1_re raised at word 1 → after the 4th mem_ready, S_TURN, then m1 owns; m0_ready=0 throughout m1's ownership; m0 regains the bus after m1 drops.
- Round robin: both request continuously with MAX_BURST=2 → grants alternate 0,1,0,1 with exactly one idle slave cycle between owners.
- Reset mid-burst: res at word 5 of an m1 write-back → next cycle mem_we=0, gnt_valid=0; stray mem_ready afterwards produces no m*_ready.
